// File: rtl/mmio_timer.sv
// -----------------------------------------------------------------------------
// mmio_timer
//   Memory-mapped machine timer. Owns the free-running cycle counter, the
//   microsecond timer mtime (also exported as time) and the compare register
//   mtimecmp, and raises a registered timer-interrupt level when
//   mtime >= mtimecmp. Register accesses arrive from the MEM stage over a
//   one-outstanding start/ready/valid handshake: stores complete in the accept
//   cycle, loads return one cycle later.
//
// Register window (16 bytes at BASE_ADDR, word offset = cmd_addr[3:2]):
//   0 : mtime[31:0]     1 : mtime[63:32]
//   2 : mtimecmp[31:0]  3 : mtimecmp[63:32]
//
// Ports
//   clk           in   1   core clock
//   rst           in   1   synchronous, active-high reset
//   cmd_start     in   1   request valid
//   cmd_write     in   1   1 = store, 0 = load
//   cmd_addr      in   32  byte address
//   cmd_wdata     in   32  store data
//   cmd_ready     out  1   request can be accepted this cycle
//   rdata_valid   out  1   one-cycle load-response strobe
//   rdata         out  32  load response data
//   reg_cycle     out  64  clock counter
//   reg_time      out  64  same value as reg_mtime
//   reg_mtime     out  64  microsecond timer
//   reg_mtimecmp  out  64  compare value
//   timer_irq     out  1   registered (mtime >= mtimecmp)
// -----------------------------------------------------------------------------
module mmio_timer #(
  parameter int          FMAX_MHz  = 27,
  parameter logic [31:0] BASE_ADDR = 32'hf000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ready,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic [63:0] reg_cycle,
  output logic [63:0] reg_time,
  output logic [63:0] reg_mtime,
  output logic [63:0] reg_mtimecmp,
  output logic        timer_irq
);

  // Prescaler width; FMAX_MHz = 1 still needs a one-bit counter that stays 0.
  localparam int PW = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(FMAX_MHz - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [1:0] OFF_MTIME_LO = 2'd0;
  localparam logic [1:0] OFF_MTIME_HI = 2'd1;
  localparam logic [1:0] OFF_CMP_LO   = 2'd2;
  localparam logic [1:0] OFF_CMP_HI   = 2'd3;

  // Selects the 32-bit half of a timer register named by a word offset.
  function automatic logic [31:0] read_mux(
    input logic [1:0]  off,
    input logic [63:0] mtime,
    input logic [63:0] mtimecmp
  );
    logic [31:0] val;
    case (off)
      OFF_MTIME_LO: val = mtime[31:0];
      OFF_MTIME_HI: val = mtime[63:32];
      OFF_CMP_LO:   val = mtimecmp[31:0];
      OFF_CMP_HI:   val = mtimecmp[63:32];
      default:      val = 32'h0000_0000;
    endcase
    return val;
  endfunction

  logic [0:0]    r_state;
  logic [63:0]   r_cycle;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic [PW-1:0] r_presc;
  logic [31:0]   r_rdata;
  logic          r_rdata_valid;
  logic          r_irq;

  logic          w_hit;
  logic [1:0]    w_off;
  logic          w_accept;
  logic          w_store;
  logic          w_load;
  logic          w_tick;
  logic [63:0]   w_mtime_nxt;
  logic [63:0]   w_mtimecmp_nxt;
  logic          w_unused_addr_lsbs;

  assign w_hit    = (cmd_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off    = cmd_addr[3:2];
  assign w_accept = cmd_start & (r_state == ST_IDLE);
  assign w_store  = w_accept & cmd_write & w_hit;
  // Loads are accepted on a miss too; they simply return zero.
  assign w_load   = w_accept & ~cmd_write;
  assign w_tick   = (r_presc == PRESC_MAX);

  // Byte-lane bits are not part of the word decode.
  assign w_unused_addr_lsbs = ^cmd_addr[1:0];

  // Next mtime: a store to either half wins over a simultaneous tick, and the
  // dropped tick never carries into the unwritten half.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_store && (w_off == OFF_MTIME_LO)) begin
      w_mtime_nxt = {r_mtime[63:32], cmd_wdata};
    end else if (w_store && (w_off == OFF_MTIME_HI)) begin
      w_mtime_nxt = {cmd_wdata, r_mtime[31:0]};
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end else begin
      w_mtime_nxt = r_mtime;
    end
  end

  // Next mtimecmp: only the addressed half of a store changes.
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_store && (w_off == OFF_CMP_LO)) begin
      w_mtimecmp_nxt = {r_mtimecmp[63:32], cmd_wdata};
    end else if (w_store && (w_off == OFF_CMP_HI)) begin
      w_mtimecmp_nxt = {cmd_wdata, r_mtimecmp[31:0]};
    end else begin
      w_mtimecmp_nxt = r_mtimecmp;
    end
  end

  // Free-running clock counter, wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= 64'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
    end
  end

  // Prescaler dividing the core clock down to 1 us ticks; it keeps running
  // across a write/tick collision so the tick phase is undisturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Timer and compare registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hffff_ffff_ffff_ffff;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
    end
  end

  // Handshake FSM: a load parks in RESP for one cycle to present its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_load ? ST_RESP : ST_IDLE;
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Load response: snapshot of the addressed register at the accept edge,
  // taken before that edge's tick or store lands. Held between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata       <= 32'h0000_0000;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_load;
      if (w_load) begin
        r_rdata <= w_hit ? read_mux(w_off, r_mtime, r_mtimecmp) : 32'h0000_0000;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Interrupt level, one cycle behind the live register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  assign cmd_ready    = (r_state == ST_IDLE);
  assign rdata_valid  = r_rdata_valid;
  assign rdata        = r_rdata;
  assign reg_cycle    = r_cycle;
  assign reg_time     = r_mtime;
  assign reg_mtime    = r_mtime;
  assign reg_mtimecmp = r_mtimecmp;
  assign timer_irq    = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// -----------------------------------------------------------------------------
// tb_mmio_timer
//   Directed bench for mmio_timer (FMAX_MHz = 27). Inputs change 1 ns after a
//   rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hf000_0000;
  localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;

  logic        clk;
  logic        rst;
  logic        cmd_start;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic [63:0] reg_cycle;
  logic [63:0] reg_time;
  logic [63:0] reg_mtime;
  logic [63:0] reg_mtimecmp;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  mmio_timer #(
    .FMAX_MHz (27),
    .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_start   (cmd_start),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_ready   (cmd_ready),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .reg_cycle   (reg_cycle),
    .reg_time    (reg_time),
    .reg_mtime   (reg_mtime),
    .reg_mtimecmp(reg_mtimecmp),
    .timer_irq   (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    cmd_start = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = addr;
    cmd_wdata = data;
    step(1);
    cmd_start = 1'b0;
    cmd_write = 1'b0;
  endtask

  // Returns sampled in the RESP cycle.
  task automatic do_load(input logic [31:0] addr);
    cmd_start = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addr;
    step(1);
    cmd_start = 1'b0;
  endtask

  initial begin
    logic        found;
    logic [63:0] m0;

    rst       = 1'b1;
    cmd_start = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0000;
    cmd_wdata = 32'h0000_0000;
    step(3);
    rst = 1'b0;

    // Reset state
    check("rst_cycle",    reg_cycle,    64'd0);
    check("rst_mtime",    reg_mtime,    64'd0);
    check("rst_mtimecmp", reg_mtimecmp, ONES);
    check("rst_ready",    {63'd0, cmd_ready},   64'd1);
    check("rst_valid",    {63'd0, rdata_valid}, 64'd0);
    check("rst_rdata",    {32'd0, rdata},       64'd0);
    check("rst_irq",      {63'd0, timer_irq},   64'd0);

    // Idle 10 cycles
    step(10);
    check("idle_cycle", reg_cycle, 64'd10);
    check("idle_mtime", reg_mtime, 64'd0);
    check("idle_irq",   {63'd0, timer_irq}, 64'd0);
    check("idle_ready", {63'd0, cmd_ready}, 64'd1);

    // Prescaler: 134 edges -> 4 ticks, 135 -> 5
    step(124);
    check("presc_134", reg_mtime, 64'd4);
    step(1);
    check("presc_135", reg_mtime, 64'd5);
    check("time_eq",   reg_time,  64'd5);
    check("cycle_135", reg_cycle, 64'd135);

    // mtimecmp = 100 written in halves
    do_store(BASE + 32'h8, 32'h0000_0064);
    check("cmp_lo_only", reg_mtimecmp, 64'hffff_ffff_0000_0064);
    do_store(BASE + 32'hc, 32'h0000_0000);
    check("cmp_100", reg_mtimecmp, 64'd100);
    check("irq_below", {63'd0, timer_irq}, 64'd0);

    // Jump mtime to 98 and wait for 100
    do_store(BASE + 32'h0, 32'd98);
    check("mtime_98", reg_mtime, 64'd98);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      found = (reg_mtime == 64'd100);
    end
    check("wait_mtime_100", {63'd0, found}, 64'd1);
    check("irq_lag", {63'd0, timer_irq}, 64'd0);
    step(1);
    check("irq_rise", {63'd0, timer_irq}, 64'd1);
    step(30);
    check("irq_level", {63'd0, timer_irq}, 64'd1);

    // Raising mtimecmp drops the level one cycle later
    do_store(BASE + 32'hc, 32'hffff_ffff);
    check("cmp_raised", reg_mtimecmp, 64'hffff_ffff_0000_0064);
    step(1);
    check("irq_fall", {63'd0, timer_irq}, 64'd0);

    // Load of mtime lo right after writing it; a start during RESP is ignored
    do_store(BASE + 32'h0, 32'h0000_1234);
    check("pre_load_ready", {63'd0, cmd_ready}, 64'd1);
    do_load(BASE + 32'h0);
    check("resp_ready", {63'd0, cmd_ready},   64'd0);
    check("resp_valid", {63'd0, rdata_valid}, 64'd1);
    check("resp_rdata", {32'd0, rdata},       64'h1234);
    cmd_start = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = BASE + 32'h8;
    cmd_wdata = 32'h0000_5555;
    step(1);
    cmd_start = 1'b0;
    cmd_write = 1'b0;
    check("post_valid",   {63'd0, rdata_valid}, 64'd0);
    check("post_ready",   {63'd0, cmd_ready},   64'd1);
    check("ignored_st",   reg_mtimecmp, 64'hffff_ffff_0000_0064);
    check("rdata_hold",   {32'd0, rdata}, 64'h1234);

    // Compare reads, byte-lane bits ignored
    do_load(BASE + 32'hf);
    check("rd_cmp_hi", {32'd0, rdata}, 64'hffff_ffff);
    step(1);
    do_load(BASE + 32'ha);
    check("rd_cmp_lo", {32'd0, rdata}, 64'h64);
    step(1);

    // Decode misses
    do_load(BASE + 32'h10);
    check("miss_valid", {63'd0, rdata_valid}, 64'd1);
    check("miss_rdata", {32'd0, rdata}, 64'd0);
    step(1);
    do_store(BASE + 32'h18, 32'h0000_0077);
    do_store(32'h0000_0008, 32'h0000_0088);
    check("miss_store", reg_mtimecmp, 64'hffff_ffff_0000_0064);

    // Write/tick collision: sync to a tick, then store on the next tick edge
    do_store(BASE + 32'h4, 32'h0000_0000);
    m0 = reg_mtime;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      found = (reg_mtime != m0);
    end
    check("tick_sync", {63'd0, found}, 64'd1);
    step(26);
    do_store(BASE + 32'h0, 32'hffff_ffff);
    check("coll_val", reg_mtime, 64'h0000_0000_ffff_ffff);
    step(26);
    check("coll_hold", reg_mtime, 64'h0000_0000_ffff_ffff);
    step(1);
    check("coll_carry", reg_mtime, 64'h0000_0001_0000_0000);
    do_load(BASE + 32'h4);
    check("rd_mtime_hi", {32'd0, rdata}, 64'h1);
    step(1);

    // Reset during RESP discards the response
    do_load(BASE + 32'h8);
    check("pre_rst_valid", {63'd0, rdata_valid}, 64'd1);
    rst = 1'b1;
    step(1);
    check("rst_resp_valid", {63'd0, rdata_valid}, 64'd0);
    check("rst_resp_rdata", {32'd0, rdata},       64'd0);
    check("rst_resp_ready", {63'd0, cmd_ready},   64'd1);
    check("rst2_mtime",     reg_mtime,    64'd0);
    check("rst2_cmp",       reg_mtimecmp, ONES);
    rst = 1'b0;
    step(1);
    check("rst2_cycle", reg_cycle, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
